// File: rtl/parking_ctrl_if.sv
// Gate-sequencer signal bundle: event inputs from the lot sensors and
// billing terminal, plus the display-facing outputs.
interface parking_ctrl_if;
    logic       power;
    logic       car_in;
    logic       car_out;
    logic       time_tick;
    logic       is_night;
    logic       pay;
    logic [5:0] count;
    logic [2:0] scan_cnt;
    logic       flicker_clk;
    logic       delay;
    logic       need_pay;
    logic [5:0] time_day;
    logic [4:0] time_night;
    logic [1:0] state_o;

    modport master (
        output power, car_in, car_out, time_tick, is_night, pay,
        input  count, scan_cnt, flicker_clk, delay, need_pay,
               time_day, time_night, state_o
    );

    modport slave (
        input  power, car_in, car_out, time_tick, is_night, pay,
        output count, scan_cnt, flicker_clk, delay, need_pay,
               time_day, time_night, state_o
    );
endinterface

// File: rtl/parking_ctrl.sv
// Parking-lot gate sequencer: occupancy count, single-vehicle metering FSM,
// display scan counter and flicker clock.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no metered vehicle; unmetered departures decrement count
// PARKED   | metered vehicle present; time_tick accumulates hours
// NEED_PAY | metered vehicle left; waiting for payment, times frozen
// DELAY    | payment accepted; holding for DELAY_CYCLES before IDLE
module parking_ctrl #(
    parameter int unsigned CAPACITY     = 50,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned FLICKER_DIV  = 25000,
    parameter int unsigned DELAY_CYCLES = 100000
) (
    input logic            clk,
    input logic            rst,
    parking_ctrl_if.slave  bus
);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int FLK_W  = $clog2(FLICKER_DIV + 1);
    localparam int DLY_W  = $clog2(DELAY_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PARKED   = 2'd1,
        S_NEED_PAY = 2'd2,
        S_DELAY    = 2'd3
    } state_t;

    state_t              state;
    logic [5:0]          count;
    logic [2:0]          scan_cnt;
    logic                flicker_clk;
    logic [5:0]          time_day;
    logic [4:0]          time_night;
    logic [SCAN_W-1:0]   scan_pre;
    logic [FLK_W-1:0]    flk_pre;
    logic [DLY_W-1:0]    dly_cnt;

    logic                inc;
    logic                dec;
    logic [8:0]          day_nx;
    logic [8:0]          night_nx;
    logic [8:0]          money_nx;
    logic                tick_ok;

    always_comb begin
        inc = bus.car_in && (count < 6'(CAPACITY));
        dec = 1'b0;
        case (state)
            S_IDLE:     dec = bus.car_out && (count != 6'd0);
            S_NEED_PAY: dec = bus.pay && (count != 6'd0);
            default:    dec = 1'b0;
        endcase
    end

    // A tick is kept only if the billing amount 2*day+night stays two digits.
    always_comb begin
        day_nx   = {3'b000, time_day} + {8'd0, ~bus.is_night};
        night_nx = {4'b0000, time_night} + {8'd0, bus.is_night};
        money_nx = {day_nx[7:0], 1'b0} + night_nx;
        tick_ok  = (day_nx <= 9'd63) && (night_nx <= 9'd31) &&
                   ((day_nx + night_nx) <= 9'd63) && (money_nx <= 9'd99);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= 6'd0;
            scan_cnt    <= 3'd0;
            flicker_clk <= 1'b0;
            time_day    <= 6'd0;
            time_night  <= 5'd0;
            scan_pre    <= '0;
            flk_pre     <= '0;
            dly_cnt     <= '0;
        end else begin
            if (scan_pre == SCAN_W'(SCAN_DIV - 1)) begin
                scan_pre <= '0;
                scan_cnt <= scan_cnt + 3'd1;
            end else begin
                scan_pre <= scan_pre + 1'b1;
            end

            if (flk_pre == FLK_W'(FLICKER_DIV - 1)) begin
                flk_pre     <= '0;
                flicker_clk <= ~flicker_clk;
            end else begin
                flk_pre <= flk_pre + 1'b1;
            end

            if (!bus.power) begin
                state      <= S_IDLE;
                time_day   <= 6'd0;
                time_night <= 5'd0;
                dly_cnt    <= '0;
            end else begin
                if (inc && !dec)
                    count <= count + 6'd1;
                else if (dec && !inc)
                    count <= count - 6'd1;

                case (state)
                    S_IDLE: begin
                        if (inc) begin
                            state      <= S_PARKED;
                            time_day   <= 6'd0;
                            time_night <= 5'd0;
                        end
                    end
                    S_PARKED: begin
                        if (bus.time_tick && tick_ok) begin
                            time_day   <= day_nx[5:0];
                            time_night <= night_nx[4:0];
                        end
                        if (bus.car_out)
                            state <= S_NEED_PAY;
                    end
                    S_NEED_PAY: begin
                        if (bus.pay) begin
                            state   <= S_DELAY;
                            dly_cnt <= DLY_W'(DELAY_CYCLES - 1);
                        end
                    end
                    S_DELAY: begin
                        if (dly_cnt == '0) begin
                            state      <= S_IDLE;
                            time_day   <= 6'd0;
                            time_night <= 5'd0;
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.count       = count;
    assign bus.scan_cnt    = scan_cnt;
    assign bus.flicker_clk = flicker_clk;
    assign bus.time_day    = time_day;
    assign bus.time_night  = time_night;
    assign bus.need_pay    = (state == S_NEED_PAY);
    assign bus.delay       = (state == S_DELAY);
    assign bus.state_o     = state;
endmodule
